biestables_bank: RTL and testbench
==================================

Name: biestables_bank

Overview:
- Parametrised bank of W edge-triggered flip-flops sharing one clock.
- Operating mode (SR, JK, D, T) is selectable at run time.
- Successor to the single-type SR flip-flops: adds width, run-time type selection, clock enable, a configurable illegal-SR policy, per-bit change flags and a sticky error flag.
- Used as the generic state-storage primitive in lesson-level sequential designs and in their benches.

Parameters:
- W, 4: number of flip-flop channels (1..32).
- EDGE, 0: active clock edge; 0 = falling edge of ck, 1 = rising edge. Every register in the block uses this edge.
- SR11, 0: policy for s=r=1 in SR mode; 0 = hold, 1 = force 0, 2 = force 1, 3 = toggle.
- INIT, 0: W-bit value loaded into q by reset.

Ports:
- ck  in  1  clock; single clock domain, active edge per EDGE.
- cl  in  1  reset; synchronous, active-low. Sampled on the active edge of ck.
- en  in  1  clock enable; 0 = all channels hold.
- mode  in  2  flip-flop type: 0 SR, 1 JK, 2 D, 3 T.
- a  in  W  first data input per channel: s / j / d / t, depending on mode.
- b  in  W  second data input per channel: r / k; ignored in D and T modes.
- q  out  W  flip-flop state.
- chg  out  W  per-bit flag; 1 when that bit of q changed on the last active edge.
- err  out  1  sticky flag; set when any channel saw s=r=1 in SR mode.

Behaviour:
- All state updates occur only on the active edge of ck. There are no asynchronous paths.
- Reset (cl=0 at an active edge):
  - q <= INIT, chg <= 0, err <= 0.
  - Reset has priority over en, mode and data.
  - Reset mid-operation discards any pending update on that edge.
- Hold (cl=1, en=0): q holds, chg <= 0, err holds.
- Update (cl=1, en=1), per channel i, with next value nq[i]:
  - SR: 00 hold; 10 -> 1; 01 -> 0; 11 -> per SR11.
  - JK: 00 hold; 10 -> 1; 01 -> 0; 11 -> ~q[i].
  - D: nq[i] = a[i].
  - T: nq[i] = q[i] ^ a[i].
- Change flags: chg[i] <= (nq[i] != q[i]).
  - Registered, so chg is valid for exactly one cycle after the edge that changed q.
- Error flag:
  - err <= err | (mode==SR & |(a & b)). Evaluated only when en=1.
  - Cleared only by reset.
  - err is set regardless of the SR11 policy.
- Latency: q reflects its inputs one active edge after they are sampled.
- Mode changes take effect on the same edge that samples them. No state is carried between modes.
- Inputs must be stable around the active edge. The bench changes inputs away from the active edge.
- Outputs are driven directly from registers.

Optional Feature:
- Macro: BIESTABLES_ERRCNT_EN.
- With the macro defined:
  - Extra output ecnt, 8 bits.
  - ecnt counts the active edges (en=1, mode=SR) on which at least one channel has s=r=1.
  - ecnt saturates at 255 and resets to 0.
- Without the macro: no ecnt port, no counter logic. All other behaviour is identical.

Decomposition:
- Shared package biestables_pkg:
  - Mode constants MODE_SR=2'd0, MODE_JK=2'd1, MODE_D=2'd2, MODE_T=2'd3.
  - SR11 policy constants SR11_HOLD, SR11_ZERO, SR11_ONE, SR11_TOGGLE.
- One natural sub-module, biestable_cell: combinational next-state logic for one channel (mode, a, b, q, SR11 -> nq, illegal).
  - The top instantiates W cells in a generate loop.
  - The top owns all registers.

Test Plan:
- Reset: W=4, INIT=4'b1010, cl=0 for one edge with en=1, mode=D, a=4'b0101 -> q=4'b1010, chg=0, err=0; cl=1 on the next edge -> q=4'b0101, chg=4'b1111.
- SR sequence (mirrors the lesson waveform): mode=SR, r=1 at t=8 -> q=0 after the next active edge; s pulse 34-36 not spanning a falling edge (EDGE=0) -> q unchanged; s=1 at t=52 -> q=1 at the edge at t=60.
- Illegal SR: SR11=3, q=4'b0011, a=b=4'b0101 -> q=4'b0110, err=1 and stays 1 after a=b=0; with BIESTABLES_ERRCNT_EN defined, 300 such edges -> ecnt=255.
- JK/T: mode=JK, j=k=4'b1111 for 3 edges -> q alternates 1111/0000, chg=4'b1111 each cycle; mode=T, a=4'b0001 -> only q[0] toggles, chg=4'b0001.
- Enable: en=0, mode=D, a=4'b1111 for 5 edges -> q unchanged, chg=0; en=1 -> q=4'b1111 after one edge.
- Edge parameter: EDGE=1 -> D input changed just before a falling edge is not captured until the following rising edge.

Source files
------------

// File: rtl/biestables_pkg.sv
// Shared constants for the flip-flop bank: operating-mode encodings,
// illegal-SR (s=r=1) policy codes and the error-counter helper.
package biestables_pkg;

  // Flip-flop type selected by the mode input
  localparam logic [1:0] MODE_SR = 2'd0;
  localparam logic [1:0] MODE_JK = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_T  = 2'd3;

  // What an SR channel does when s and r are both high
  localparam int SR11_HOLD   = 0;
  localparam int SR11_ZERO   = 1;
  localparam int SR11_ONE    = 2;
  localparam int SR11_TOGGLE = 3;

  // Illegal-SR event counter width and ceiling
  localparam int         ECNT_W   = 8;
  localparam logic [7:0] ECNT_MAX = 8'hFF;

  // Saturating increment for the illegal-SR event counter
  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    return (v == ECNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/biestable_cell.sv
// Next-state logic for a single flip-flop channel. Purely combinational:
// given the current state q, the mode and the two data inputs, it produces
// the value q should take on the next enabled edge, and flags s=r=1 in SR mode.
module biestable_cell
  import biestables_pkg::*;
#(
  parameter int SR11 = SR11_HOLD
) (
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       nq,
  output logic       illegal
);

  // Decode the channel's next state for the selected flip-flop type
  always_comb begin
    nq      = q;
    illegal = 1'b0;
    case (mode)
      MODE_SR: begin
        // s=r=1 is reported as illegal no matter which policy resolves it
        illegal = a & b;
        case ({a, b})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11: begin
            case (SR11)
              SR11_ZERO:   nq = 1'b0;
              SR11_ONE:    nq = 1'b1;
              SR11_TOGGLE: nq = ~q;
              default:     nq = q;
            endcase
          end
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = a;
      default: nq = q ^ a;
    endcase
  end

endmodule

// File: rtl/biestables_bank.sv
// Bank of W flip-flops with run-time selectable type (SR/JK/D/T), clock
// enable, per-bit change flags and a sticky illegal-SR error flag.
// All registers share one clock edge chosen by EDGE (0 = falling, 1 = rising);
// reset cl is synchronous and active-low.
// Optional: define BIESTABLES_ERRCNT_EN to add the 8-bit saturating ecnt
// output counting enabled SR edges on which any channel had s=r=1.
module biestables_bank
  import biestables_pkg::*;
#(
  parameter int           W    = 4,
  parameter int           EDGE = 0,
  parameter int           SR11 = SR11_HOLD,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         ck,
  input  logic         cl,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] chg,
  output logic         err
`ifdef BIESTABLES_ERRCNT_EN
  ,
  output logic [7:0]   ecnt
`endif
);

  logic [W-1:0] nq;
  logic [W-1:0] illegal;
  logic [W-1:0] q_nx;
  logic [W-1:0] chg_nx;
  logic         err_nx;
  logic         any_illegal;

  for (genvar i = 0; i < W; i++) begin : g_cell
    biestable_cell #(
      .SR11(SR11)
    ) u_cell (
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .nq      (nq[i]),
      .illegal (illegal[i])
    );
  end

  assign any_illegal = |illegal;

  // Apply the clock enable: when disabled everything holds and no bit reports a change
  always_comb begin
    q_nx   = q;
    chg_nx = '0;
    err_nx = err;
    if (en) begin
      q_nx   = nq;
      chg_nx = nq ^ q;
      err_nx = err | any_illegal;
    end
  end

  // The edge is fixed at elaboration; only one of these register sets exists
  if (EDGE != 0) begin : g_rise
    // State, change flags and sticky error, updated on the rising edge
    always_ff @(posedge ck) begin
      if (!cl) begin
        q   <= INIT;
        chg <= '0;
        err <= 1'b0;
      end else begin
        q   <= q_nx;
        chg <= chg_nx;
        err <= err_nx;
      end
    end
  end else begin : g_fall
    // State, change flags and sticky error, updated on the falling edge
    always_ff @(negedge ck) begin
      if (!cl) begin
        q   <= INIT;
        chg <= '0;
        err <= 1'b0;
      end else begin
        q   <= q_nx;
        chg <= chg_nx;
        err <= err_nx;
      end
    end
  end

`ifdef BIESTABLES_ERRCNT_EN
  logic [7:0] ecnt_nx;

  // Count enabled edges that saw s=r=1 on any SR channel, stopping at 255
  always_comb begin
    ecnt_nx = ecnt;
    if (en && any_illegal) begin
      ecnt_nx = sat_inc(ecnt);
    end
  end

  if (EDGE != 0) begin : g_ecnt_rise
    // Illegal-SR event counter on the rising edge
    always_ff @(posedge ck) begin
      if (!cl) begin
        ecnt <= '0;
      end else begin
        ecnt <= ecnt_nx;
      end
    end
  end else begin : g_ecnt_fall
    // Illegal-SR event counter on the falling edge
    always_ff @(negedge ck) begin
      if (!cl) begin
        ecnt <= '0;
      end else begin
        ecnt <= ecnt_nx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_biestables_bank.sv
// Directed bench for biestables_bank. Four instances share one set of inputs:
//   u0: EDGE=0, SR11=toggle, INIT=4'b1010 (main checks)
//   u1: EDGE=1, SR11=hold               (rising-edge behaviour)
//   u2: EDGE=0, SR11=force 0
//   u3: EDGE=0, SR11=force 1
// Falling edges at 10n, rising at 10n+5. Inputs change at 10n+2 unless a
// test needs otherwise; outputs are sampled at 10n+2 / 10n+7.
// Honours BIESTABLES_ERRCNT_EN when the RTL is built with it.
`timescale 1ns/1ps
module tb_biestables_bank;

  logic       ck;
  logic       cl;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;

  logic [3:0] q0, chg0, q1, chg1, q2, chg2, q3, chg3;
  logic       err0, err1, err2, err3;
`ifdef BIESTABLES_ERRCNT_EN
  logic [7:0] ecnt0, ecnt1, ecnt2, ecnt3;
`endif

  int checks;
  int failures;

  biestables_bank #(.W(4), .EDGE(0), .SR11(3), .INIT(4'b1010)) u0 (
    .ck(ck), .cl(cl), .en(en), .mode(mode), .a(a), .b(b),
    .q(q0), .chg(chg0), .err(err0)
`ifdef BIESTABLES_ERRCNT_EN
    , .ecnt(ecnt0)
`endif
  );

  biestables_bank #(.W(4), .EDGE(1), .SR11(0), .INIT(4'b0000)) u1 (
    .ck(ck), .cl(cl), .en(en), .mode(mode), .a(a), .b(b),
    .q(q1), .chg(chg1), .err(err1)
`ifdef BIESTABLES_ERRCNT_EN
    , .ecnt(ecnt1)
`endif
  );

  biestables_bank #(.W(4), .EDGE(0), .SR11(1), .INIT(4'b0000)) u2 (
    .ck(ck), .cl(cl), .en(en), .mode(mode), .a(a), .b(b),
    .q(q2), .chg(chg2), .err(err2)
`ifdef BIESTABLES_ERRCNT_EN
    , .ecnt(ecnt2)
`endif
  );

  biestables_bank #(.W(4), .EDGE(0), .SR11(2), .INIT(4'b0000)) u3 (
    .ck(ck), .cl(cl), .en(en), .mode(mode), .a(a), .b(b),
    .q(q3), .chg(chg3), .err(err3)
`ifdef BIESTABLES_ERRCNT_EN
    , .ecnt(ecnt3)
`endif
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic at(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with a pending D load that must be discarded
    cl = 1'b0; en = 1'b1; mode = 2'd2; a = 4'b0101; b = 4'b0000;
    at(12);
    check("rst_q0",   q0,   4'b1010);
    check("rst_chg0", chg0, 4'b0000);
    check("rst_err0", err0, 1'b0);
    check("rst_q1",   q1,   4'b0000);
    cl = 1'b1;
    at(22);
    check("d_after_rst_q0",   q0,   4'b0101);
    check("d_after_rst_chg0", chg0, 4'b1111);
    check("d_after_rst_q1",   q1,   4'b0101);
    check("d_after_rst_chg1", chg1, 4'b0101);

    // SR lesson waveform, offset by 30
    mode = 2'd0; a = 4'b0000; b = 4'b0000;
    at(38); b = 4'b1111;
    at(42);
    check("sr_r_q0",   q0,   4'b0000);
    check("sr_r_chg0", chg0, 4'b0101);
    check("sr_r_err0", err0, 1'b0);
    at(48); b = 4'b0000;
    at(64); a = 4'b1111;
    at(66); a = 4'b0000;
    at(67);
    check("sr_pulse_rise_q1", q1, 4'b1111);
    at(72);
    check("sr_pulse_q0",   q0,   4'b0000);
    check("sr_pulse_chg0", chg0, 4'b0000);
    at(82); a = 4'b1111;
    at(88);
    check("sr_s_before_edge_q0", q0, 4'b0000);
    at(92);
    check("sr_s_q0",   q0,   4'b1111);
    check("sr_s_chg0", chg0, 4'b1111);
    check("sr_s_q1",   q1,   4'b1111);

    // Illegal SR from q=0011 with a=b=0101 under each policy
    mode = 2'd2; a = 4'b0011; b = 4'b0000;
    at(102);
    check("load_0011_q0", q0, 4'b0011);
    mode = 2'd0; a = 4'b0101; b = 4'b0101;
    at(112);
    check("sr11_tog_q0",   q0,   4'b0110);
    check("sr11_tog_chg0", chg0, 4'b0101);
    check("sr11_tog_err0", err0, 1'b1);
    check("sr11_hold_q1",  q1,   4'b0011);
    check("sr11_hold_chg1", chg1, 4'b0000);
    check("sr11_hold_err1", err1, 1'b1);
    check("sr11_zero_q2",  q2,   4'b0010);
    check("sr11_zero_chg2", chg2, 4'b0001);
    check("sr11_one_q3",   q3,   4'b0111);
    check("sr11_one_chg3", chg3, 4'b0100);
`ifdef BIESTABLES_ERRCNT_EN
    check("ecnt_one_q0", ecnt0, 8'd1);
`endif
    a = 4'b0000; b = 4'b0000;
    at(122);
    check("err_sticky_err0", err0, 1'b1);
    check("err_sticky_q0",   q0,   4'b0110);
    check("err_sticky_chg0", chg0, 4'b0000);

    // Reset mid-operation beats a pending JK toggle and clears err
    cl = 1'b0; mode = 2'd1; a = 4'b1111; b = 4'b1111;
    at(132);
    check("rst_mid_q0",   q0,   4'b1010);
    check("rst_mid_chg0", chg0, 4'b0000);
    check("rst_mid_err0", err0, 1'b0);
    cl = 1'b1; mode = 2'd2; a = 4'b0000; b = 4'b0000;

    // JK toggle for three edges
    at(142);
    check("load_0000_q0", q0, 4'b0000);
    mode = 2'd1; a = 4'b1111; b = 4'b1111;
    at(152);
    check("jk_t1_q0",   q0,   4'b1111);
    check("jk_t1_chg0", chg0, 4'b1111);
    at(162);
    check("jk_t2_q0",   q0,   4'b0000);
    check("jk_t2_chg0", chg0, 4'b1111);
    at(172);
    check("jk_t3_q0",   q0,   4'b1111);
    check("jk_t3_chg0", chg0, 4'b1111);
    check("jk_no_err0", err0, 1'b0);
    a = 4'b0000; b = 4'b0011;
    at(182);
    check("jk_k_q0",   q0,   4'b1100);
    check("jk_k_chg0", chg0, 4'b0011);
    a = 4'b0001; b = 4'b0000;
    at(192);
    check("jk_j_q0",   q0,   4'b1101);
    check("jk_j_chg0", chg0, 4'b0001);

    // T mode toggles only the bits with a=1
    mode = 2'd3; a = 4'b0001;
    at(202);
    check("t_1_q0",   q0,   4'b1100);
    check("t_1_chg0", chg0, 4'b0001);
    at(212);
    check("t_2_q0",   q0,   4'b1101);
    check("t_2_chg0", chg0, 4'b0001);

    // Enable low for five edges, then one enabled edge
    en = 1'b0; mode = 2'd2; a = 4'b1111;
    at(222);
    check("en0_first_q0",   q0,   4'b1101);
    check("en0_first_chg0", chg0, 4'b0000);
    at(262);
    check("en0_last_q0",   q0,   4'b1101);
    check("en0_last_chg0", chg0, 4'b0000);
    en = 1'b1;
    at(272);
    check("en1_q0",   q0,   4'b1111);
    check("en1_chg0", chg0, 4'b0010);

    // Illegal SR while disabled must not set err
    en = 1'b0; mode = 2'd0; a = 4'b1111; b = 4'b1111;
    at(282);
    check("en0_sr11_err0", err0, 1'b0);
    check("en0_sr11_q0",   q0,   4'b1111);

    // D change just before a falling edge: rising-edge instance waits
    en = 1'b1; mode = 2'd2; a = 4'b0000; b = 4'b0000;
    at(298); a = 4'b1010;
    at(302);
    check("edge_fall_q0", q0, 4'b1010);
    check("edge_rise_hold_q1", q1, 4'b0000);
`ifdef BIESTABLES_ERRCNT_EN
    check("ecnt_zero_q0", ecnt0, 8'd0);
`endif
    at(307);
    check("edge_rise_q1",   q1,   4'b1010);
    check("edge_rise_chg1", chg1, 4'b1010);

`ifdef BIESTABLES_ERRCNT_EN
    // 300 illegal edges saturate the counter
    mode = 2'd0; a = 4'b1111; b = 4'b1111;
    at(3302);
    check("ecnt_sat_q0", ecnt0, 8'd255);
    check("ecnt_sat_err0", err0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
